// File: rtl/id_exe_reg_pkg.sv
// Shared width/id defines and the update-priority helper for the ID/EX pipeline register.
// Define ID_EXE_PERF_EN at build time to enable the bubble/flush performance counters.
`ifndef ID_EXE_REG_DEFINES
`define ID_EXE_REG_DEFINES
`define GPR_WIDTH      32
`define SYS_ADDR_SPACE 32
`define GPR_ADDR_SPACE 5
`define IMM_WIDTH      32
`define INST_ID_LEN    8
`define INST_ID_NOP    0
`endif

package id_exe_reg_pkg;

    typedef enum logic [1:0] {
        UpdCapture,
        UpdBubble,
        UpdHold,
        UpdFlush
    } upd_e;

    // Flush beats stall, stall beats a load-use bubble.
    function automatic upd_e upd_sel(input logic flush, input logic stall, input logic load_use);
        if (flush) begin
            return UpdFlush;
        end else if (stall) begin
            return UpdHold;
        end else if (load_use) begin
            return UpdBubble;
        end
        return UpdCapture;
    endfunction

endpackage

// File: rtl/id_exe_reg_hazard_detect.sv
// Combinational load-use hazard compare between a decode-side consumer and a registered load.
// Kept separate so execute-side forwarding logic can reuse it.
module id_exe_reg_hazard_detect #(
    parameter int unsigned RW = `GPR_ADDR_SPACE
) (
    input  logic          valid_i,
    input  logic          rs1_re_i,
    input  logic [RW-1:0] rs1_addr_i,
    input  logic          rs2_re_i,
    input  logic [RW-1:0] rs2_addr_i,
    input  logic          ex_valid_i,
    input  logic          ex_mem_re_i,
    input  logic          ex_rd_we_i,
    input  logic [RW-1:0] ex_rd_addr_i,
    output logic          load_use_o
);

    logic ex_load;
    logic src_match;

    always_comb begin
        ex_load    = ex_valid_i & ex_mem_re_i & ex_rd_we_i & (ex_rd_addr_i != '0);
        src_match  = (rs1_re_i & (rs1_addr_i == ex_rd_addr_i)) |
                     (rs2_re_i & (rs2_addr_i == ex_rd_addr_i));
        load_use_o = valid_i & ex_load & src_match;
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, back-pressure hold and flush.
// Optional perf counters are built when ID_EXE_PERF_EN is defined.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int unsigned XLEN = `GPR_WIDTH,
    parameter int unsigned AW   = `SYS_ADDR_SPACE,
    parameter int unsigned RW   = `GPR_ADDR_SPACE,
    parameter int unsigned IW   = `IMM_WIDTH,
    parameter int unsigned IDW  = `INST_ID_LEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [AW-1:0]   pc_i,
    input  logic [RW-1:0]   rs1_addr_i,
    input  logic [RW-1:0]   rs2_addr_i,
    input  logic            rs1_re_i,
    input  logic            rs2_re_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [RW-1:0]   rd_addr_i,
    input  logic            rd_we_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [IDW-1:0]  instr_id_i,
    input  logic [IW-1:0]   imm_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [AW-1:0]   pc_o,
    output logic [RW-1:0]   rs1_addr_o,
    output logic [RW-1:0]   rs2_addr_o,
    output logic            rs1_re_o,
    output logic            rs2_re_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [RW-1:0]   rd_addr_o,
    output logic            rd_we_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic [IDW-1:0]  instr_id_o,
    output logic [IW-1:0]   imm_o,
    output logic            hold_o,
    output logic            load_use_o,
    output logic [31:0]     bubble_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    logic            valid_q, valid_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [RW-1:0]   rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic            rs1_re_q, rs1_re_d, rs2_re_q, rs2_re_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic            rd_we_q, rd_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [IDW-1:0]  instr_id_q, instr_id_d;
    logic [IW-1:0]   imm_q, imm_d;
    logic            load_use;
    upd_e            upd;

    id_exe_reg_hazard_detect #(
        .RW (RW)
    ) u_hazard_detect (
        .valid_i      (valid_i),
        .rs1_re_i     (rs1_re_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_re_i     (rs2_re_i),
        .rs2_addr_i   (rs2_addr_i),
        .ex_valid_i   (valid_q),
        .ex_mem_re_i  (mem_re_q),
        .ex_rd_we_i   (rd_we_q),
        .ex_rd_addr_i (rd_addr_q),
        .load_use_o   (load_use)
    );

    assign upd        = upd_sel(flush_i, stall_i, load_use);
    assign load_use_o = load_use;
    assign hold_o     = stall_i | (load_use & ~flush_i);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_re_d   = rs1_re_q;
        rs2_re_d   = rs2_re_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        mem_re_d   = mem_re_q;
        mem_we_d   = mem_we_q;
        instr_id_d = instr_id_q;
        imm_d      = imm_q;
        unique case (upd)
            UpdFlush: begin
                valid_d  = 1'b0;
                rd_we_d  = 1'b0;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
            UpdHold: ;
            UpdBubble: begin
                valid_d    = 1'b0;
                rd_we_d    = 1'b0;
                mem_re_d   = 1'b0;
                mem_we_d   = 1'b0;
                instr_id_d = IDW'(`INST_ID_NOP);
            end
            UpdCapture: begin
                valid_d    = valid_i;
                pc_d       = pc_i;
                rs1_addr_d = rs1_addr_i;
                rs2_addr_d = rs2_addr_i;
                rs1_re_d   = rs1_re_i;
                rs2_re_d   = rs2_re_i;
                rs1_val_d  = rs1_val_i;
                rs2_val_d  = rs2_val_i;
                rd_addr_d  = rd_addr_i;
                // Enables never leave this stage without a valid bundle.
                rd_we_d    = rd_we_i & valid_i;
                mem_re_d   = mem_re_i & valid_i;
                mem_we_d   = mem_we_i & valid_i;
                instr_id_d = instr_id_i;
                imm_d      = imm_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_re_q   <= 1'b0;
            rs2_re_q   <= 1'b0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            instr_id_q <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_re_q   <= rs1_re_d;
            rs2_re_q   <= rs2_re_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            instr_id_q <= instr_id_d;
            imm_q      <= imm_d;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign rs1_addr_o = rs1_addr_q;
    assign rs2_addr_o = rs2_addr_q;
    assign rs1_re_o   = rs1_re_q;
    assign rs2_re_o   = rs2_re_q;
    assign rs1_val_o  = rs1_val_q;
    assign rs2_val_o  = rs2_val_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_we_o    = rd_we_q;
    assign mem_re_o   = mem_re_q;
    assign mem_we_o   = mem_we_q;
    assign instr_id_o = instr_id_q;
    assign imm_o      = imm_q;

`ifdef ID_EXE_PERF_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (upd == UpdBubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (flush_i && (valid_q || valid_i)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Table-driven bench for id_exe_reg: hazard/hold checks before each edge, bundle checks after.
module tb_id_exe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, rs1_re_i, rs2_re_i, rd_we_i, mem_re_i, mem_we_i, stall_i, flush_i;
    logic [31:0] pc_i, rs1_val_i, rs2_val_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [7:0]  instr_id_i;
    logic        valid_o, rs1_re_o, rs2_re_o, rd_we_o, mem_re_o, mem_we_o, hold_o, load_use_o;
    logic [31:0] pc_o, rs1_val_o, rs2_val_o, imm_o, bubble_cnt_o, flush_cnt_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [7:0]  instr_id_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_reg dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_re_i     (rs1_re_i),
        .rs2_re_i     (rs2_re_i),
        .rs1_val_i    (rs1_val_i),
        .rs2_val_i    (rs2_val_i),
        .rd_addr_i    (rd_addr_i),
        .rd_we_i      (rd_we_i),
        .mem_re_i     (mem_re_i),
        .mem_we_i     (mem_we_i),
        .instr_id_i   (instr_id_i),
        .imm_i        (imm_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .rs1_re_o     (rs1_re_o),
        .rs2_re_o     (rs2_re_o),
        .rs1_val_o    (rs1_val_o),
        .rs2_val_o    (rs2_val_o),
        .rd_addr_o    (rd_addr_o),
        .rd_we_o      (rd_we_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .instr_id_o   (instr_id_o),
        .imm_o        (imm_o),
        .hold_o       (hold_o),
        .load_use_o   (load_use_o),
        .bubble_cnt_o (bubble_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    typedef struct {
        logic        vi;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic        r1e;
        logic [4:0]  rs2;
        logic        r2e;
        logic [4:0]  rd;
        logic        we, mre, mwe;
        logic [7:0]  id;
        logic        stall, flush;
        logic        e_lu, e_hold;
        logic        e_v;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic        e_we, e_mre, e_mwe;
        logic [7:0]  e_id;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        valid_i    = v.vi;
        pc_i       = v.pc;
        rs1_addr_i = v.rs1;
        rs1_re_i   = v.r1e;
        rs2_addr_i = v.rs2;
        rs2_re_i   = v.r2e;
        rd_addr_i  = v.rd;
        rd_we_i    = v.we;
        mem_re_i   = v.mre;
        mem_we_i   = v.mwe;
        instr_id_i = v.id;
        stall_i    = v.stall;
        flush_i    = v.flush;
        rs1_val_i  = 32'hAAAA0000 | v.pc;
        rs2_val_i  = 32'h55550000 | v.pc;
        imm_i      = 32'h00001000 | v.pc;
        #1;
        chk($sformatf("v%0d load_use", idx), 32'(load_use_o), 32'(v.e_lu));
        chk($sformatf("v%0d hold", idx), 32'(hold_o), 32'(v.e_hold));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d valid", idx), 32'(valid_o), 32'(v.e_v));
        chk($sformatf("v%0d pc", idx), pc_o, v.e_pc);
        chk($sformatf("v%0d rd_addr", idx), 32'(rd_addr_o), 32'(v.e_rd));
        chk($sformatf("v%0d rd_we", idx), 32'(rd_we_o), 32'(v.e_we));
        chk($sformatf("v%0d mem_re", idx), 32'(mem_re_o), 32'(v.e_mre));
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we_o), 32'(v.e_mwe));
        chk($sformatf("v%0d instr_id", idx), 32'(instr_id_o), 32'(v.e_id));
        if (!valid_o) begin
            chk($sformatf("v%0d idle enables", idx), 32'({rd_we_o, mem_re_o, mem_we_o}), 32'd0);
        end
    endtask

    initial begin
        // vi pc rs1 r1e rs2 r2e rd we mre mwe id stall flush | lu hold | v pc rd we mre mwe id
        vecs[0]  = '{1, 32'h00, 1, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h00, 3, 1, 0, 0, 1};
        vecs[1]  = '{1, 32'h04, 3, 1, 0, 0, 4, 1, 0, 0, 2, 0, 0, 0, 0, 1, 32'h04, 4, 1, 0, 0, 2};
        vecs[2]  = '{1, 32'h08, 2, 1, 0, 0, 5, 1, 1, 0, 3, 0, 0, 0, 0, 1, 32'h08, 5, 1, 1, 0, 3};
        vecs[3]  = '{1, 32'h0C, 5, 1, 1, 1, 6, 1, 0, 0, 4, 0, 0, 1, 1, 0, 32'h08, 5, 0, 0, 0, 0};
        vecs[4]  = '{1, 32'h0C, 5, 1, 1, 1, 6, 1, 0, 0, 4, 0, 0, 0, 0, 1, 32'h0C, 6, 1, 0, 0, 4};
        vecs[5]  = '{1, 32'h10, 6, 1, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 32'h10, 0, 1, 1, 0, 3};
        vecs[6]  = '{1, 32'h14, 0, 1, 0, 0, 7, 1, 0, 0, 4, 0, 0, 0, 0, 1, 32'h14, 7, 1, 0, 0, 4};
        vecs[7]  = '{1, 32'h18, 1, 1, 2, 1, 8, 1, 0, 1, 5, 1, 0, 0, 1, 1, 32'h14, 7, 1, 0, 0, 4};
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = '{1, 32'h18, 1, 1, 2, 1, 8, 1, 0, 1, 5, 0, 0, 0, 0, 1, 32'h18, 8, 1, 0, 1, 5};
        vecs[11] = '{0, 32'h1C, 1, 1, 0, 0, 9, 1, 1, 1, 6, 0, 0, 0, 0, 0, 32'h1C, 9, 0, 0, 0, 6};
        vecs[12] = '{1, 32'h20, 1, 1, 0, 0, 9, 1, 1, 0, 3, 0, 0, 0, 0, 1, 32'h20, 9, 1, 1, 0, 3};
        vecs[13] = '{1, 32'h24, 3, 1, 9, 1, 10, 1, 0, 0, 7, 1, 0, 1, 1, 1, 32'h20, 9, 1, 1, 0, 3};
        vecs[14] = '{1, 32'h24, 3, 1, 9, 1, 10, 1, 0, 0, 7, 0, 0, 1, 1, 0, 32'h20, 9, 0, 0, 0, 0};
        vecs[15] = '{1, 32'h24, 3, 1, 9, 1, 10, 1, 0, 0, 7, 0, 0, 0, 0, 1, 32'h24, 10, 1, 0, 0, 7};
        vecs[16] = '{1, 32'h28, 1, 1, 0, 0, 11, 1, 1, 0, 3, 0, 0, 0, 0, 1, 32'h28, 11, 1, 1, 0, 3};
        vecs[17] = '{1, 32'h2C, 11, 1, 0, 0, 12, 1, 0, 0, 8, 1, 1, 1, 1, 0, 32'h28, 11, 0, 0, 0, 3};
        vecs[18] = '{1, 32'h30, 1, 1, 0, 0, 12, 1, 1, 0, 3, 0, 0, 0, 0, 1, 32'h30, 12, 1, 1, 0, 3};
        vecs[19] = '{1, 32'h34, 12, 1, 0, 0, 13, 1, 0, 0, 9, 0, 1, 1, 0, 0, 32'h30, 12, 0, 0, 0, 3};
        vecs[20] = '{1, 32'h38, 2, 1, 3, 1, 14, 1, 0, 1, 10, 0, 0, 0, 0, 1, 32'h38, 14, 1, 0, 1, 10};

        rst_n = 1'b0;
        apply_idle();
        #2;
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset pc", pc_o, 32'd0);
        chk("reset enables", 32'({rd_we_o, mem_re_o, mem_we_o, rs1_re_o, rs2_re_o}), 32'd0);
        chk("reset instr_id", 32'(instr_id_o), 32'd0);
        chk("reset bubble_cnt", bubble_cnt_o, 32'd0);
        chk("reset flush_cnt", flush_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], i);
        end

        chk("rs1_val", rs1_val_o, 32'hAAAA0038);
        chk("rs2_val", rs2_val_o, 32'h55550038);
        chk("imm", imm_o, 32'h00001038);
        chk("rs1_addr", 32'(rs1_addr_o), 32'd2);
        chk("rs2_addr", 32'(rs2_addr_o), 32'd3);
        chk("src enables", 32'({rs1_re_o, rs2_re_o}), 32'd3);
`ifdef ID_EXE_PERF_EN
        chk("bubble_cnt", bubble_cnt_o, 32'd2);
        chk("flush_cnt", flush_cnt_o, 32'd2);
`else
        chk("bubble_cnt", bubble_cnt_o, 32'd0);
        chk("flush_cnt", flush_cnt_o, 32'd0);
`endif

        // Asynchronous reset mid-cycle with a valid bundle latched.
        apply_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(valid_o), 32'd0);
        chk("async rst pc", pc_o, 32'd0);
        chk("async rst rd_we/mem_we", 32'({rd_we_o, mem_we_o}), 32'd0);
        chk("async rst instr_id", 32'(instr_id_o), 32'd0);
        chk("async rst rs1_val", rs1_val_o, 32'd0);
        chk("async rst flush_cnt", flush_cnt_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic apply_idle();
        valid_i    = 1'b0;
        pc_i       = '0;
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        rs1_re_i   = 1'b0;
        rs2_re_i   = 1'b0;
        rs1_val_i  = '0;
        rs2_val_i  = '0;
        rd_addr_i  = '0;
        rd_we_i    = 1'b0;
        mem_re_i   = 1'b0;
        mem_we_i   = 1'b0;
        instr_id_i = '0;
        imm_i      = '0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
    endtask

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures the decoded instruction bundle (pc, operand values, immediate, register addresses, control enables, instruction id) and carries a valid bit.
- Resolves three hazard and control events: the load-use hazard (stall plus bubble), downstream back-pressure (hold) and a redirect from execute (flush).
- Drives a hold request upstream to the IF/ID register and PC.

Parameters:
- XLEN, `GPR_WIDTH (32): operand/register value width.
- AW, `SYS_ADDR_SPACE (32): pc width.
- RW, `GPR_ADDR_SPACE (5): register address width.
- IW, `IMM_WIDTH (32): immediate width.
- IDW, `INST_ID_LEN: instruction id width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  decode-side bundle valid.
- pc_i  in  AW  decode pc.
- rs1_addr_i, rs2_addr_i  in  RW  source register addresses.
- rs1_re_i, rs2_re_i  in  1  source read enables.
- rs1_val_i, rs2_val_i  in  XLEN  register file read data.
- rd_addr_i  in  RW  destination register.
- rd_we_i, mem_re_i, mem_we_i  in  1  control enables.
- instr_id_i  in  IDW  decoded instruction id.
- imm_i  in  IW  immediate.
- stall_i  in  1  downstream back-pressure; execute cannot accept.
- flush_i  in  1  redirect from execute; kill the younger instruction.
- valid_o, pc_o, rs1_addr_o, rs2_addr_o, rs1_re_o, rs2_re_o, rs1_val_o, rs2_val_o, rd_addr_o, rd_we_o, mem_re_o, mem_we_o, instr_id_o, imm_o  out  (same widths)  registered bundle to execute.
- hold_o  out  1  upstream must hold pc and IF/ID contents this cycle.
- load_use_o  out  1  load-use hazard detected this cycle.
- bubble_cnt_o, flush_cnt_o  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset: asynchronous on rst_n_i low. Every output register clears to 0, including valid_o and all enables. Counters clear to 0.
- Reset mid-operation discards the bundle immediately, with no partial write-back.
- Load-use detect is combinational and must not depend on stall_i:
  - load_use_o = valid_i & valid_o & mem_re_o & rd_we_o & (rd_addr_o != 0) & ((rs1_re_i & rs1_addr_i == rd_addr_o) | (rs2_re_i & rs2_addr_i == rd_addr_o)).
- hold_o = stall_i | (load_use_o & ~flush_i).
- Register update priority at each rising edge, highest first:
  1. flush_i = 1: valid_o <= 0 and rd_we_o, mem_re_o, mem_we_o <= 0. Data fields are don't-care but are held. Flush wins over stall_i and over load-use.
  2. stall_i = 1: all outputs hold their current values.
  3. load_use_o = 1: insert a bubble. valid_o, rd_we_o, mem_re_o, mem_we_o <= 0, instr_id_o <= 0. Upstream holds via hold_o, so the consumer re-presents on the next cycle.
  4. Otherwise: capture all inputs. valid_o <= valid_i.
     - When valid_i = 0, rd_we_o, mem_re_o and mem_we_o are forced to 0.
- Latency is 1 cycle from decode inputs to execute outputs.
- A load-use stall costs exactly 1 bubble. On the following cycle rd_addr_o belongs to the bubble (valid_o = 0), so the hazard clears and the consumer is captured.
- rd_addr 0 never triggers a hazard.
- When load_use and stall_i occur together, hold wins. The hazard is re-evaluated on the next cycle.
- Enables are never asserted while valid_o = 0; verification checks this as an invariant.
- There is no internal state machine beyond the valid bit. The bubble counts as state because the hazard compare uses the registered bundle.

Optional Feature:
- Macro: ID_EXE_PERF_EN.
- When defined:
  - bubble_cnt_o increments on each edge where a load-use bubble is inserted.
  - flush_cnt_o increments on each edge where flush_i kills a valid_o = 1 entry or a valid_i = 1 entry.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops exist. The port list is identical in both builds.

Decomposition:
- Shared defines header holds the width macros, `INST_ID_LEN and the NOP instruction id value (0). Use these; do not redefine them locally.
- One natural sub-module: hazard_detect (pure combinational load-use compare), instantiated once, so execute-side forwarding can reuse it later.

Test Plan:
- Back-to-back ALU ops: valid_i = 1, pc 0x00 then 0x04, no hazard -> valid_o = 1 with pc_o 0x00 then 0x04, one cycle later; hold_o = 0.
- Load x5, then add x6,x5,x1: lw latched (mem_re_o = 1, rd_addr_o = 5); add presented -> load_use_o = 1, hold_o = 1. Next cycle valid_o = 0, rd_we_o = 0. Following cycle the add is latched with pc_o = 0x04.
- Load to x0, then consumer reading x0 -> load_use_o = 0; no bubble.
- stall_i = 1 for 3 cycles with pc_o = 0x10 latched -> outputs frozen at 0x10, hold_o = 1; stall_i drops -> next bundle captured.
- flush_i and stall_i asserted together with valid_o = 1 -> next edge valid_o = 0 and all enables 0. With ID_EXE_PERF_EN defined, flush_cnt_o increments 0 -> 1.
- rst_n_i pulsed low mid-cycle with valid_o = 1 -> outputs clear to 0 immediately, without waiting for a clock edge.
